// File: rtl/trigger_arbiter.sv
// trigger_arbiter: qualifies trigger lines by their stable-high time, picks one round-robin,
// issues a single start pulse, then waits for the acquisition engine and a holdoff before re-arming.
module trigger_arbiter #(
    parameter int N_SRC     = 4,
    parameter int STABLE_W  = 4,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_in,
    input  logic [N_SRC-1:0]     src_en,
    input  logic [STABLE_W-1:0]  stable_len,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 auto_rearm,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 acq_done,
    output logic                 trig,
    output logic [N_SRC-1:0]     trig_src,
    output logic                 armed,
    output logic                 busy,
    output logic [7:0]           miss_cnt
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FIRE,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [STABLE_W-1:0]  cnt_q [N_SRC];
    logic [STABLE_W-1:0]  cnt_d [N_SRC];
    logic [N_SRC-1:0]     done_q, done_d;
    logic [N_SRC-1:0]     qual_q, qual_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [N_SRC-1:0]     trig_src_q, trig_src_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic [7:0]           miss_cnt_q, miss_cnt_d;

    logic [STABLE_W-1:0]  len_m1;
    logic                 found;
    logic [PW-1:0]        gidx;
    logic [N_SRC-1:0]     grant_oh;
    logic                 take;
    logic [N_SRC-1:0]     miss_vec;

    // Per-source qualify counters; qual is registered so FIRE lands exactly L edges after first high sample
    always_comb begin
        len_m1 = (stable_len == '0) ? '0 : stable_len - 1'b1;
        done_d = done_q;
        qual_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!(src_in[i] & src_en[i])) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (!done_q[i]) begin
                if (cnt_q[i] >= len_m1) begin
                    qual_d[i] = 1'b1;
                    done_d[i] = 1'b1;
                end
                if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search for the first qualified source at or after the pointer
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        grant_oh = '0;
        for (int off = 0; off < N_SRC; off++) begin
            int idx;
            idx = int'(rr_q) + off;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!found && qual_q[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        grant_oh[gidx] = found;
    end

    // Sequencer next state, grant capture, holdoff countdown and miss accounting
    always_comb begin
        int unsigned acc;
        state_d    = state_q;
        rr_d       = rr_q;
        trig_src_d = trig_src_q;
        hcnt_d     = hcnt_q;
        take       = (state_q == S_ARMED) && !disarm && found;
        miss_vec   = take ? (qual_q & ~grant_oh) : qual_q;
        acc        = 32'(miss_cnt_q);
        for (int i = 0; i < N_SRC; i++) begin
            acc = acc + 32'(miss_vec[i]);
        end
        miss_cnt_d = (acc > 32'd255) ? 8'hFF : acc[7:0];
        case (state_q)
            S_IDLE: begin
                if (arm && !disarm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    state_d    = S_FIRE;
                    trig_src_d = grant_oh;
                    rr_d       = (gidx == PW'(N_SRC - 1)) ? '0 : gidx + 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (acq_done) begin
                    if (holdoff != '0) begin
                        state_d = S_HOLD;
                        hcnt_d  = holdoff - 1'b1;
                    end else begin
                        state_d = auto_rearm ? S_ARMED : S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (hcnt_q == '0) begin
                    state_d = auto_rearm ? S_ARMED : S_IDLE;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= '0;
            qual_q     <= '0;
            rr_q       <= '0;
            trig_src_q <= '0;
            hcnt_q     <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            qual_q     <= qual_d;
            rr_q       <= rr_d;
            trig_src_q <= trig_src_d;
            hcnt_q     <= hcnt_d;
            miss_cnt_q <= miss_cnt_d;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign trig     = (state_q == S_FIRE);
    assign trig_src = trig_src_q;
    assign armed    = (state_q == S_ARMED);
    assign busy     = (state_q == S_FIRE) || (state_q == S_BUSY) || (state_q == S_HOLD);
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_trigger_arbiter.sv
// tb_trigger_arbiter: directed vectors for trigger_arbiter
// with hand-computed expectations.
module tb_trigger_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_in;
    logic [3:0]  src_en;
    logic [3:0]  stable_len;
    logic [15:0] holdoff;
    logic        auto_rearm;
    logic        arm;
    logic        disarm;
    logic        acq_done;
    logic        trig;
    logic [3:0]  trig_src;
    logic        armed;
    logic        busy;
    logic [7:0]  miss_cnt;

    int errors = 0;
    int checks = 0;

    trigger_arbiter #(.N_SRC(4), .STABLE_W(4), .HOLDOFF_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_in     (src_in),
        .src_en     (src_en),
        .stable_len (stable_len),
        .holdoff    (holdoff),
        .auto_rearm (auto_rearm),
        .arm        (arm),
        .disarm     (disarm),
        .acq_done   (acq_done),
        .trig       (trig),
        .trig_src   (trig_src),
        .armed      (armed),
        .busy       (busy),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n edges; inputs and samples both land 1ns after the edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] s);
        src_in = s;
        tick();
        src_in = 4'h0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic done_cycle();
        acq_done = 1'b1;
        tick();
        acq_done = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        src_in     = '0;
        src_en     = 4'hF;
        stable_len = 4'd3;
        holdoff    = 16'd0;
        auto_rearm = 1'b0;
        arm        = 1'b0;
        disarm     = 1'b0;
        acq_done   = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_src", 32'(trig_src), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miss", 32'(miss_cnt), 32'd0);

        // 1: source 2 held high 3 cycles with stable_len=3
        do_arm();
        check("t1_armed", 32'(armed), 32'd1);
        src_in = 4'b0100;
        tick(2);
        check("t1_no_trig_k1", 32'(trig), 32'd0);
        tick();
        src_in = 4'h0;
        check("t1_no_trig_k2", 32'(trig), 32'd0);
        tick();
        check("t1_trig", 32'(trig), 32'd1);
        check("t1_src", 32'(trig_src), 32'h4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_armed_lo", 32'(armed), 32'd0);
        tick();
        check("t1_trig_1cyc", 32'(trig), 32'd0);
        check("t1_src_held", 32'(trig_src), 32'h4);
        done_cycle();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_armed", 32'(armed), 32'd0);

        // 2: too-short high period, then single-cycle pulses with stable_len=0
        do_arm();
        src_in = 4'b0010;
        tick(2);
        src_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("t2_short_no_trig", 32'(trig), 32'd0);
            tick();
        end
        check("t2_still_armed", 32'(armed), 32'd1);
        check("t2_miss", 32'(miss_cnt), 32'd0);
        stable_len = 4'd0;
        pulse(4'b0010);
        tick();
        check("t2_p1_trig", 32'(trig), 32'd1);
        check("t2_p1_src", 32'(trig_src), 32'h2);
        tick();
        done_cycle();
        do_arm();
        pulse(4'b1000);
        tick();
        check("t2_p2_trig", 32'(trig), 32'd1);
        check("t2_p2_src", 32'(trig_src), 32'h8);
        tick();
        done_cycle();

        // 3: sources 0 and 3 together, pointer back at 0
        do_arm();
        pulse(4'b1001);
        tick();
        check("t3_a_trig", 32'(trig), 32'd1);
        check("t3_a_src", 32'(trig_src), 32'h1);
        check("t3_a_miss", 32'(miss_cnt), 32'd1);
        tick();
        done_cycle();
        do_arm();
        pulse(4'b1001);
        tick();
        check("t3_b_trig", 32'(trig), 32'd1);
        check("t3_b_src", 32'(trig_src), 32'h8);
        check("t3_b_miss", 32'(miss_cnt), 32'd2);
        tick();

        // 4: holdoff=5 with auto re-arm, a qual arrives during holdoff
        holdoff    = 16'd5;
        auto_rearm = 1'b1;
        done_cycle();
        check("t4_hold_busy", 32'(busy), 32'd1);
        check("t4_hold_armed", 32'(armed), 32'd0);
        pulse(4'b0100);
        tick();
        check("t4_hold_miss", 32'(miss_cnt), 32'd3);
        tick();
        check("t4_hold3_armed", 32'(armed), 32'd0);
        tick();
        check("t4_hold4_armed", 32'(armed), 32'd0);
        tick();
        check("t4_rearm", 32'(armed), 32'd1);
        check("t4_rearm_busy", 32'(busy), 32'd0);

        // 5: disarm beats a coincident qual; arm+disarm in IDLE
        pulse(4'b0001);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("t5_disarm", 32'(armed), 32'd0);
        check("t5_no_trig", 32'(trig), 32'd0);
        tick();
        check("t5_no_trig2", 32'(trig), 32'd0);
        check("t5_no_busy", 32'(busy), 32'd0);
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        check("t5_arm_dis", 32'(armed), 32'd0);

        // 6: reset in BUSY, reset in HOLDOFF, miss counter saturation
        auto_rearm = 1'b0;
        do_arm();
        pulse(4'b0100);
        tick(2);
        check("t6_in_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rb_busy", 32'(busy), 32'd0);
        check("t6_rb_src", 32'(trig_src), 32'd0);
        check("t6_rb_miss", 32'(miss_cnt), 32'd0);
        do_arm();
        pulse(4'b0010);
        tick(2);
        done_cycle();
        tick(2);
        check("t6_in_hold", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rh_busy", 32'(busy), 32'd0);
        check("t6_rh_armed", 32'(armed), 32'd0);
        check("t6_rh_trig", 32'(trig), 32'd0);
        check("t6_rh_src", 32'(trig_src), 32'd0);
        for (int i = 0; i < 254; i++) begin
            pulse(4'b0001);
            tick();
        end
        check("t6_miss_254", 32'(miss_cnt), 32'd254);
        for (int i = 0; i < 46; i++) begin
            pulse(4'b0001);
            tick();
        end
        check("t6_miss_sat", 32'(miss_cnt), 32'd255);
        check("t6_unarmed_trig", 32'(trig), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
